// File: rtl/tlc_lamp_monitor.sv
// tlc_lamp_monitor: latches lamp conflicts/invalid codes into a failsafe FAULT; in m1/mt/m2/s_in {r,y,g}, fault_clr; out lamp_m1/mt/m2/s, fault, fault_code {invalid,conflict}; TLC_FAILSAFE_FLASH_EN makes the failsafe red flash
module tlc_lamp_monitor #(
  parameter int STARTUP_CYC = 4,
  parameter int FAULT_FILT = 2,
  parameter int BLINK_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] m1_in,
  input  logic [2:0] mt_in,
  input  logic [2:0] m2_in,
  input  logic [2:0] s_in,
  input  logic       fault_clr,
  output logic [2:0] lamp_m1,
  output logic [2:0] lamp_mt,
  output logic [2:0] lamp_m2,
  output logic [2:0] lamp_s,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam logic [2:0] RED = 3'b100;
  localparam int IW = $clog2(STARTUP_CYC + 1);
  localparam int FW = $clog2(FAULT_FILT + 1);
  typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;
  state_t state;
  logic [IW-1:0] init_cnt;
  logic [FW-1:0] filt;
  logic [1:0] pend, code;
  logic conflict, invalid, viol;
  function automatic logic act(input logic [2:0] b);
    return b == 3'b001 || b == 3'b010;
  endfunction
  function automatic logic bad(input logic [2:0] b);
    return !(b == 3'b100 || b == 3'b010 || b == 3'b001);
  endfunction
  always_comb begin
    conflict = (act(s_in) && (act(m1_in) || act(mt_in) || act(m2_in))) || (act(m2_in) && act(mt_in));
    invalid = bad(m1_in) || bad(mt_in) || bad(m2_in) || bad(s_in);
    viol = conflict || invalid;
    code = {invalid, conflict};
  end
`ifdef TLC_FAILSAFE_FLASH_EN
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  logic [BW-1:0] bcnt;
  logic phase, wrap, nphase;
  always_comb begin
    wrap = bcnt == BW'(BLINK_HALF - 1);
    nphase = wrap ? ~phase : phase;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      {lamp_m1, lamp_mt, lamp_m2, lamp_s} <= {4{RED}};
      fault <= 1'b0;
      fault_code <= 2'b00;
      init_cnt <= '0;
      filt <= '0;
      pend <= 2'b00;
`ifdef TLC_FAILSAFE_FLASH_EN
      bcnt <= '0;
      phase <= 1'b0;
`endif
    end else begin
      case (state)
        INIT: begin
          {lamp_m1, lamp_mt, lamp_m2, lamp_s} <= {4{RED}};
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == IW'(STARTUP_CYC - 1)) begin
            state <= RUN;
            init_cnt <= '0;
          end
        end
        RUN: begin
          if (!viol) begin
            {lamp_m1, lamp_mt, lamp_m2, lamp_s} <= {m1_in, mt_in, m2_in, s_in};
            filt <= '0;
          end else begin
            pend <= pend | code;
            filt <= (filt == FW'(FAULT_FILT)) ? filt : filt + 1'b1;
            // this edge samples the FAULT_FILT-th consecutive violation
            if (filt == FW'(FAULT_FILT - 1)) begin
              state <= FAULT;
              fault <= 1'b1;
              fault_code <= pend | code;
              {lamp_m1, lamp_mt, lamp_m2, lamp_s} <= {4{RED}};
`ifdef TLC_FAILSAFE_FLASH_EN
              bcnt <= '0;
              phase <= 1'b1;
`endif
            end
          end
        end
        FAULT: begin
          if (fault_clr && !viol) begin
            state <= INIT;
            fault <= 1'b0;
            fault_code <= 2'b00;
            pend <= 2'b00;
            filt <= '0;
            init_cnt <= '0;
            {lamp_m1, lamp_mt, lamp_m2, lamp_s} <= {4{RED}};
`ifdef TLC_FAILSAFE_FLASH_EN
            bcnt <= '0;
            phase <= 1'b0;
          end else begin
            bcnt <= wrap ? '0 : bcnt + 1'b1;
            phase <= nphase;
            {lamp_m1, lamp_mt, lamp_m2, lamp_s} <= {4{nphase ? RED : 3'b000}};
`endif
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// tb_tlc_lamp_monitor: randomized scoreboard bench for tlc_lamp_monitor against a rule-level reference model
module tb_tlc_lamp_monitor;
  localparam int SC = 4, FF = 2, BH = 8;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] m1_in = R, mt_in = R, m2_in = R, s_in = R;
  logic fault_clr = 1'b0;
  logic [2:0] lamp_m1, lamp_mt, lamp_m2, lamp_s;
  logic fault;
  logic [1:0] fault_code;
  typedef struct packed {logic [11:0] l; logic f; logic [1:0] c;} obs_t;
  obs_t q[$];
  obs_t e, a;
  int checks = 0, fails = 0;
  int mode = 0, since = 0, run_v = 0;
  logic [1:0] m_pend = 0, m_code = 0;
  logic m_fault = 0;
  logic [11:0] m_l = {4{R}};
  tlc_lamp_monitor #(.STARTUP_CYC(SC), .FAULT_FILT(FF), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .m1_in(m1_in), .mt_in(mt_in), .m2_in(m2_in), .s_in(s_in),
    .fault_clr(fault_clr), .lamp_m1(lamp_m1), .lamp_mt(lamp_mt), .lamp_m2(lamp_m2),
    .lamp_s(lamp_s), .fault(fault), .fault_code(fault_code)
  );
  always #5 clk = ~clk;
  function automatic logic act(input logic [2:0] b);
    return b inside {3'b001, 3'b010};
  endfunction
  function automatic logic inval(input logic [2:0] b);
    return !(b inside {3'b100, 3'b010, 3'b001});
  endfunction
  function automatic logic [11:0] flash(input int t);
`ifdef TLC_FAILSAFE_FLASH_EN
    return ((t / BH) % 2 == 0) ? {4{R}} : 12'h000;
`else
    return {4{R}};
`endif
  endfunction
  always @(posedge clk) begin
    logic cf, iv;
    cf = (act(s_in) && (act(m1_in) || act(mt_in) || act(m2_in))) || (act(m2_in) && act(mt_in));
    iv = inval(m1_in) || inval(mt_in) || inval(m2_in) || inval(s_in);
    if (rst) begin
      mode = 0; since = 0; run_v = 0; m_pend = 0; m_code = 0; m_fault = 0; m_l = {4{R}};
    end else if (mode == 0) begin
      since++;
      m_l = {4{R}};
      if (since == SC) begin mode = 1; since = 0; end
    end else if (mode == 1) begin
      if (!(cf || iv)) begin
        m_l = {m1_in, mt_in, m2_in, s_in};
        run_v = 0;
      end else begin
        m_pend = m_pend | {iv, cf};
        run_v++;
        if (run_v == FF) begin
          mode = 2; since = 0; m_fault = 1; m_code = m_pend; m_l = flash(0);
        end
      end
    end else begin
      if (fault_clr && !(cf || iv)) begin
        mode = 0; since = 0; run_v = 0; m_pend = 0; m_code = 0; m_fault = 0; m_l = {4{R}};
      end else begin
        since++;
        m_l = flash(since);
      end
    end
    q.push_back('{l: m_l, f: m_fault, c: m_code});
  end
  always @(posedge clk) begin
    #1;
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = q.pop_front();
      a = '{l: {lamp_m1, lamp_mt, lamp_m2, lamp_s}, f: fault, c: fault_code};
      if (a !== e) begin
        fails++;
        $display("FAIL outputs at %0t: got lamps=%b fault=%b code=%b, expected lamps=%b fault=%b code=%b",
                 $time, a.l, a.f, a.c, e.l, e.f, e.c);
      end
    end
  end
  task automatic drive(input logic [2:0] a1, input logic [2:0] at, input logic [2:0] a2,
                       input logic [2:0] as, input logic clr, input int n);
    m1_in = a1; mt_in = at; m2_in = a2; s_in = as; fault_clr = clr;
    repeat (n) @(negedge clk);
  endtask
  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({lamp_m1, lamp_mt, lamp_m2, lamp_s, fault, fault_code} !== {12'h924, 1'b0, 2'b00}) begin
      fails++;
      $display("FAIL async_reset: got lamps=%b fault=%b code=%b, expected 100100100100 0 00",
               {lamp_m1, lamp_mt, lamp_m2, lamp_s}, fault, fault_code);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    drive(G, R, G, R, 0, 0);
    rst = 1'b0;
    drive(G, R, G, R, 0, 8);
    drive(G, R, G, G, 0, 1);
    drive(G, R, G, R, 0, 3);
    drive(Y, R, Y, R, 0, 3);
    drive(G, R, G, G, 0, 2);
    drive(G, R, G, G, 1, 3);
    drive(G, R, G, R, 0, 20);
    drive(G, R, G, R, 1, 1);
    drive(G, R, G, R, 0, 8);
    drive(G, 3'b011, G, R, 0, 2);
    drive(G, R, G, R, 0, 12);
    async_reset_check();
    drive(G, R, G, R, 0, 8);
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] b[4];
      for (int k = 0; k < 4; k++) b[k] = (3'b001 << $urandom_range(0, 2));
      if ($urandom_range(0, 9) != 0) begin
        if (act(b[3]) && (act(b[0]) || act(b[1]) || act(b[2]))) b[3] = R;
        if (act(b[1]) && act(b[2])) b[1] = R;
      end else if ($urandom_range(0, 1) != 0) begin
        b[$urandom_range(0, 3)] = 3'($urandom);
      end
      drive(b[0], b[1], b[2], b[3], ($urandom_range(0, 7) == 0), 1);
      if (i == 700) async_reset_check();
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
